// File: rtl/inst_fetch_wb.sv
// Instruction-fetch responder: turns each PC fetch request into one classic
// Wishbone read, stalls the pipeline until ack, and buffers the word across IF/ID stalls.
module inst_fetch_wb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] rd_buf;
  logic              cyc;
  logic              issue, done, capture;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  always_comb begin
    state_nx   = state;
    inst_o     = '0;
    stallreq_o = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        stallreq_o = ce_i & ~flush_i;
        if (ce_i && !flush_i) begin
          issue    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // flush wins over a coincident ack: the returned word is dropped
        if (flush_i) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (wb_ack_i) begin
          inst_o   = wb_dat_i;
          done     = 1'b1;
          capture  = 1'b1;
          state_nx = stall_i[1] ? HOLD : IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      HOLD: begin
        if (!flush_i) inst_o = rd_buf;
        if (flush_i || !stall_i[1]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_buf   <= '0;
      wb_adr_o <= '0;
      cyc      <= 1'b0;
      wb_sel_o <= 4'h0;
    end else begin
      state <= state_nx;
      if (issue) begin
        wb_adr_o <= pc_i;
        cyc      <= 1'b1;
        wb_sel_o <= 4'hF;
      end else if (done) begin
        cyc      <= 1'b0;
        wb_sel_o <= 4'h0;
      end
      if (capture) rd_buf <= wb_dat_i;
    end
  end

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = 1'b0;
  assign wb_dat_o = '0;

endmodule

// File: tb/tb_inst_fetch_wb.sv
// Scoreboard bench for inst_fetch_wb: directed test-plan sequences followed by
// randomized traffic, checked against a transaction-level fetch model.
module tb_inst_fetch_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch_wb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i), .stall_i(stall_i),
    .flush_i(flush_i), .inst_o(inst_o), .stallreq_o(stallreq_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] inst;
    logic        sr;
    logic        cyc;
    logic [3:0]  sel;
    logic [31:0] adr;
  } exp_t;

  exp_t exp_q[$];

  // Transaction-level model: is a bus read outstanding, is a word parked
  // for a stalled IF/ID stage, and what address was last put on the bus.
  bit          m_pending = 0;
  bit          m_holding = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_adr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, ".inst"},     inst_o,            e.inst);
        chk({e.tag, ".stallreq"}, {31'b0, stallreq_o}, {31'b0, e.sr});
        chk({e.tag, ".cyc"},      {31'b0, wb_cyc_o}, {31'b0, e.cyc});
        chk({e.tag, ".stb"},      {31'b0, wb_stb_o}, {31'b0, e.cyc});
        chk({e.tag, ".sel"},      {28'b0, wb_sel_o}, {28'b0, e.sel});
        chk({e.tag, ".adr"},      wb_adr_o,          e.adr);
        chk({e.tag, ".we_dat"},   {wb_dat_o[30:0], wb_we_o}, 32'h0);
      end
    end
  end

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic step(input string tag, input bit r, input bit c, input logic [31:0] p,
                      input logic [5:0] s, input bit f, input bit a,
                      input logic [31:0] d, input bit en);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ce_i = c; pc_i = p; stall_i = s; flush_i = f; wb_ack_i = a; wb_dat_i = d;
    e.tag = tag;
    e.cyc = m_pending;
    e.sel = m_pending ? 4'hF : 4'h0;
    e.adr = m_adr;
    if (m_pending) begin
      e.inst = (!f && a) ? d : 32'h0;
      e.sr   = !f && !a;
    end else if (m_holding) begin
      e.inst = f ? 32'h0 : m_word;
      e.sr   = 1'b0;
    end else begin
      e.inst = 32'h0;
      e.sr   = c && !f;
    end
    if (en) exp_q.push_back(e);
    if (r) begin
      m_pending = 0; m_holding = 0; m_word = '0; m_adr = '0;
    end else if (m_pending) begin
      if (f) m_pending = 0;
      else if (a) begin
        m_pending = 0; m_word = d; m_holding = s[1];
      end
    end else if (m_holding) begin
      if (!s[1] || f) m_holding = 0;
    end else if (c && !f) begin
      m_pending = 1; m_adr = p;
    end
  endtask

  initial begin
    int wcnt;
    bit was_pending;
    bit r, c, f, a;
    logic [31:0] p, d;
    logic [5:0] s;

    step("init", 1, 0, 0, 0, 0, 0, 0, 0);
    step("init", 1, 0, 0, 0, 0, 0, 0, 0);
    step("reset_state", 0, 0, 0, 0, 0, 0, 0, 1);

    // zero-wait fetch
    step("zw_issue", 0, 1, 32'h0, 0, 0, 0, 0, 1);
    step("zw_ack",   0, 0, 32'h0, 0, 0, 1, 32'h3401_1100, 1);
    step("zw_after", 0, 0, 32'h0, 0, 0, 0, 0, 1);

    // three wait states
    step("ws_issue", 0, 1, 32'h4, 0, 0, 0, 0, 1);
    repeat (3) step("ws_wait", 0, 1, 32'h4, 0, 0, 0, 0, 1);
    step("ws_ack",   0, 1, 32'h4, 0, 0, 1, 32'h2402_0005, 1);
    step("ws_after", 0, 0, 32'h4, 0, 0, 0, 0, 1);

    // downstream stall holds the word
    step("st_issue", 0, 1, 32'h8, 0, 0, 0, 0, 1);
    step("st_ack",   0, 1, 32'h8, 6'b000011, 0, 1, 32'hAABB_CCDD, 1);
    step("st_hold1", 0, 1, 32'hC, 6'b000011, 0, 1, 32'h5555_5555, 1);
    step("st_hold2", 0, 1, 32'hC, 6'b000000, 0, 0, 0, 1);
    step("st_idle",  0, 0, 32'hC, 0, 0, 0, 0, 1);

    // flush coincident with ack, then refetch
    step("fl_issue", 0, 1, 32'h10, 0, 0, 0, 0, 1);
    step("fl_ack",   0, 1, 32'h180, 0, 1, 1, 32'h1234_5678, 1);
    step("fl_refetch", 0, 1, 32'h180, 0, 0, 0, 0, 1);
    step("fl_busy",  0, 0, 32'h180, 0, 0, 1, 32'h0BAD_F00D, 1);

    // reset mid-transfer, late ack ignored
    step("rs_issue", 0, 1, 32'h200, 0, 0, 0, 0, 1);
    step("rs_reset", 1, 0, 32'h200, 0, 0, 0, 0, 1);
    step("rs_lateack", 0, 0, 32'h200, 0, 0, 1, 32'hDEAD_BEEF, 1);
    step("rs_after", 0, 0, 32'h200, 0, 0, 0, 0, 1);

    // fetch disabled
    repeat (10) step("ce0", 0, 0, $urandom, 6'($urandom), 0, 0, 0, 1);

    // randomized traffic with a variable-latency slave and spurious acks
    wcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 9) < 7);
      p = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      s = 6'($urandom);
      f = ($urandom_range(0, 9) == 0);
      d = $urandom;
      if (m_pending) begin
        a = (wcnt == 0);
        if (wcnt > 0) wcnt--;
      end else begin
        a = ($urandom_range(0, 7) == 0);
      end
      was_pending = m_pending;
      step("rand", r, c, p, s, f, a, d, 1);
      if (m_pending && !was_pending) wcnt = $urandom_range(0, 3);
    end

    step("drain", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_wb.md
# inst_fetch_wb

Instruction-fetch responder sitting between the PC register and the Wishbone instruction bus. It accepts the fetch request (`ce_i`, `pc_i`) the PC register issues each cycle and runs one classic Wishbone read per instruction. It holds the pipeline with `stallreq_o` until the word returns, then presents the word to the IF/ID stage. It also buffers the fetched word across downstream stalls and discards in-flight fetches on flush.

## Interface
- `ADDR_W`, 32, fetch address and Wishbone address width.
- `DATA_W`, 32, instruction and Wishbone data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ce_i`  in  1  fetch enable from the PC register; 0 means no fetch.
- `pc_i`  in  ADDR_W  fetch address, word-aligned.
- `stall_i`  in  6  pipeline stall vector; `stall_i[1]` = IF/ID stage held.
- `flush_i`  in  1  pipeline flush (exception/eret); aborts fetch.
- `inst_o`  out  DATA_W  instruction to IF/ID; 0 (nop) when none is valid.
- `stallreq_o`  out  1  stall request to the pipeline controller while a fetch is pending.
- `wb_adr_o`  out  ADDR_W  Wishbone address (registered).
- `wb_dat_o`  out  DATA_W  Wishbone write data; constant 0.
- `wb_dat_i`  in  DATA_W  Wishbone read data.
- `wb_we_o`  out  1  write enable; constant 0.
- `wb_sel_o`  out  4  byte selects; 4'hF while cycle active, else 0.
- `wb_stb_o`, `wb_cyc_o`  out  1 each  strobe and cycle (registered, always equal).
- `wb_ack_i`  in  1  slave acknowledge.

## Operation
- **State and data registers:** three-state FSM IDLE / BUSY / HOLD, plus a DATA_W read buffer `rd_buf`.
- **Reset:** state=IDLE, `rd_buf`=0, `wb_adr_o`=0, `wb_cyc_o`=`wb_stb_o`=0, `wb_sel_o`=0. After reset, `inst_o`=0 and `stallreq_o`=0 (because `ce_i`=0 is expected).
- **IDLE:**
  - `inst_o`=0. `stallreq_o` = `ce_i & ~flush_i`, combinational.
  - If `ce_i`=1 and `flush_i`=0: at the edge, `wb_adr_o`←`pc_i`, `wb_cyc_o`=`wb_stb_o`←1, `wb_sel_o`←4'hF, state→BUSY.
  - Otherwise stay in IDLE with the bus idle.
- **BUSY, `wb_ack_i`=0:**
  - `stallreq_o`=1, `inst_o`=0, and all bus outputs hold.
- **BUSY, `wb_ack_i`=1:**
  - `stallreq_o`=0 and `inst_o`=`wb_dat_i` (same-cycle bypass).
  - At the edge: cyc/stb/sel←0 and `rd_buf`←`wb_dat_i`.
  - If `stall_i[1]`=1, state→HOLD; else state→IDLE.
- **BUSY, `flush_i`=1 (overrides ack):**
  - `stallreq_o`=0 and `inst_o`=0.
  - At the edge: cyc/stb/sel←0, state→IDLE, and the returned data is discarded (`rd_buf` unchanged).
- **HOLD:**
  - `inst_o`=`rd_buf`, `stallreq_o`=0, and the bus stays idle.
  - State→IDLE at the first edge where `stall_i[1]`=0 or `flush_i`=1.
  - When leaving on flush, `inst_o`=0 in that cycle.
- **Ack outside BUSY:** `wb_ack_i` seen in IDLE or HOLD is ignored.
- **Address:** `pc_i` is never modified. Address bits [1:0] are passed through unchecked.
- **Reset mid-transfer:** reset takes priority over everything. The bus drops at the reset edge, and a late ack afterwards is ignored.

## Timing
- **Zero-wait slave:** the fetch is issued in cycle N (IDLE) and ack arrives in cycle N+1 (BUSY). `inst_o` is valid in N+1, so throughput is one instruction per 2 cycles.
- **k wait states:** `inst_o` is valid in cycle N+1+k, and `stallreq_o` is high from cycle N through N+k.
- **Stall request:** `stallreq_o` is purely combinational from state, `ce_i`, `flush_i` and `wb_ack_i`. It has no registered delay.
- **Bus outputs:** registered; they change only on clock edges.
- **Fetch cycle count:** exactly one Wishbone cycle per accepted fetch.
- **Back-to-back fetches:** cyc drops for at least one cycle between consecutive fetches.

## Test plan
- **Zero-wait fetch:** reset, then `ce_i`=1, `pc_i`=0x0000_0000, and the slave acks the cycle after stb with 0x3401_1100.
  - Required: `wb_adr_o`=0, `stallreq_o`=1 for one cycle, then `inst_o`=0x3401_1100 with `stallreq_o`=0.
  - Required: cyc low the following cycle.
- **Wait states:** ack delayed 3 cycles, `pc_i`=0x0000_0004, data 0x2402_0005.
  - Required: `stallreq_o` high for 4 consecutive cycles and cyc/stb high for 4 cycles.
  - Required: `inst_o`=0x2402_0005 only in the ack cycle.
- **Downstream stall:** `stall_i`=6'b000011 during the ack cycle with data 0xAABB_CCDD, released 2 cycles later.
  - Required: `inst_o`=0xAABB_CCDD in the ack cycle and the 2 hold cycles, then 0 in IDLE.
  - Required: no new stb until state returns to IDLE.
- **Flush in BUSY:** flush asserted in the same cycle as ack (data 0x1234_5678).
  - Required: `inst_o`=0 and `rd_buf` unchanged.
  - Required: next cycle IDLE, and a new fetch of `pc_i`=0x0000_0180 is issued if `ce_i`=1.
- **Reset mid-transfer:** reset while BUSY with no ack.
  - Required: cyc/stb/sel=0 and state IDLE after the edge.
  - Required: an ack arriving one cycle later does not change `inst_o` (stays 0).
- **`ce_i`=0:** no stb ever asserted, `stallreq_o`=0 and `inst_o`=0 throughout 10 cycles.
